pcre_chain_engine: RTL and testbench

- Parametrised successor to the per-rule generated payload engines: a one-hot NFA for a linear pattern of DEPTH positions.
- Each position is gated by one character-class match bit chosen from a shared class bus. Any position may self-loop (PCRE `+`).
- Adds anchoring, a same-edge match flag, first-match byte offset and a byte counter.
- Sits in the payload engine array, fed by the shared per-byte character-class decoder. Many instances share one cls_in bus.

---
 rtl/pcre_chain_engine.sv | 115 +++++++++++
 tb/tb_pcre_chain_engine.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcre_chain_engine.sv
`default_nettype none
// ============================================================================
// pcre_chain_engine : one-hot NFA over DEPTH class-gated positions with
// optional self-loops; match_count logic built only with PCRE_CHAIN_MATCH_COUNT_EN.
// Revision: 1.0
// ============================================================================
module pcre_chain_engine #(
  parameter int                 NUM_CLASSES = 128,
  parameter int                 DEPTH       = 11,
  parameter logic [DEPTH*8-1:0] CLASS_SEL   = {DEPTH{8'd0}},
  parameter logic [DEPTH-1:0]   LOOP_MASK   = {DEPTH{1'b0}},
  parameter bit                 ANCHORED    = 1'b0,
  parameter int                 OFF_W       = 16,
  parameter int                 CNT_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sod,
  input  logic                   en,
  input  logic [NUM_CLASSES-1:0] cls_in,
  output logic                   match,
  output logic                   match_pulse,
  output logic [OFF_W-1:0]       match_offset,
  output logic [CNT_W-1:0]       match_count,
  output logic [DEPTH-1:0]       state_vec
);

  localparam int c_CLS_SPAN = 256;

  logic [DEPTH-1:0]      r_state;
  logic [DEPTH-1:0]      w_next;
  logic                  r_first;
  logic                  r_match;
  logic                  r_pulse;
  logic [OFF_W-1:0]      r_byte_cnt;
  logic [OFF_W-1:0]      r_offset;
  logic [c_CLS_SPAN-1:0] w_cls_ext;
  logic                  w_start;
  logic                  w_hit;
  logic                  w_unused_cls;

  // Widen the class bus to the full 8-bit index range so selects never run off the end.
  for (genvar j = 0; j < c_CLS_SPAN; j++) begin : g_cls_ext
    if (j < NUM_CLASSES) begin : g_live
      assign w_cls_ext[j] = cls_in[j];
    end else begin : g_pad
      assign w_cls_ext[j] = 1'b0;
    end
  end

  assign w_unused_cls = ^w_cls_ext;
  assign w_start      = ANCHORED ? r_first : 1'b1;

  for (genvar i = 0; i < DEPTH; i++) begin : g_pos
    localparam logic [7:0] c_SEL = CLASS_SEL[8*i +: 8];
    logic w_prev;
    if (i == 0) begin : g_head
      assign w_prev = w_start;
    end else begin : g_link
      assign w_prev = r_state[i-1];
    end
    assign w_next[i] = w_cls_ext[c_SEL] & (w_prev | (LOOP_MASK[i] & r_state[i]));
  end

  // Completion is taken from the next-state term so match lands on the consuming edge.
  assign w_hit = en & w_next[DEPTH-1];

  always_ff @(posedge clk) begin
    if (rst || sod) begin
      r_state    <= '0;
      r_first    <= 1'b1;
      r_match    <= 1'b0;
      r_pulse    <= 1'b0;
      r_byte_cnt <= '0;
      r_offset   <= '0;
    end else begin
      r_pulse <= 1'b0;
      if (en) begin
        r_state <= w_next;
        r_first <= 1'b0;
        if (r_byte_cnt != {OFF_W{1'b1}}) begin
          r_byte_cnt <= r_byte_cnt + OFF_W'(1);
        end
        if (w_hit && !r_match) begin
          r_match  <= 1'b1;
          r_pulse  <= 1'b1;
          r_offset <= r_byte_cnt;
        end
      end
    end
  end

`ifdef PCRE_CHAIN_MATCH_COUNT_EN
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || sod) begin
      r_count <= '0;
    end else if (w_hit && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign match_count = r_count;
`else
  assign match_count = '0;
`endif

  assign match        = r_match;
  assign match_pulse  = r_pulse;
  assign match_offset = r_offset;
  assign state_vec    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pcre_chain_engine.sv
`default_nettype none
// ============================================================================
// tb_pcre_chain_engine : scoreboard bench for plsec_[0-9a-zA-Z]+[.]exe on
// unanchored, anchored and narrow-offset instances sharing one class bus.
// Revision: 1.0
// ============================================================================
module tb_pcre_chain_engine;

  localparam int               NC   = 128;
  localparam int               D    = 11;
  // classes: 0 p, 1 l, 2 s, 3 e, 4 c, 5 _, 6 alnum, 7 '.', 8 x
  localparam logic [D*8-1:0]   SEL  = {8'd3, 8'd8, 8'd3, 8'd7, 8'd6, 8'd5,
                                       8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
  localparam logic [D-1:0]     LOOP = 11'h040;
`ifdef PCRE_CHAIN_MATCH_COUNT_EN
  localparam int CNT_ON = 1;
`else
  localparam int CNT_ON = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sod = 1'b0;
  logic          en  = 1'b0;
  logic [NC-1:0] cls_in = '0;

  logic          m0, m1, m2, p0, p1, p2;
  logic [15:0]   o0, o1;
  logic [3:0]    o2;
  logic [7:0]    c0, c1, c2;
  logic [D-1:0]  s0, s1, s2;

  always #5 clk = ~clk;

  pcre_chain_engine #(.NUM_CLASSES(NC), .DEPTH(D), .CLASS_SEL(SEL), .LOOP_MASK(LOOP),
                      .ANCHORED(1'b0), .OFF_W(16), .CNT_W(8)) u0 (
    .clk(clk), .rst(rst), .sod(sod), .en(en), .cls_in(cls_in),
    .match(m0), .match_pulse(p0), .match_offset(o0), .match_count(c0), .state_vec(s0));

  pcre_chain_engine #(.NUM_CLASSES(NC), .DEPTH(D), .CLASS_SEL(SEL), .LOOP_MASK(LOOP),
                      .ANCHORED(1'b1), .OFF_W(16), .CNT_W(8)) u1 (
    .clk(clk), .rst(rst), .sod(sod), .en(en), .cls_in(cls_in),
    .match(m1), .match_pulse(p1), .match_offset(o1), .match_count(c1), .state_vec(s1));

  pcre_chain_engine #(.NUM_CLASSES(NC), .DEPTH(D), .CLASS_SEL(SEL), .LOOP_MASK(LOOP),
                      .ANCHORED(1'b0), .OFF_W(4), .CNT_W(8)) u2 (
    .clk(clk), .rst(rst), .sod(sod), .en(en), .cls_in(cls_in),
    .match(m2), .match_pulse(p2), .match_offset(o2), .match_count(c2), .state_vec(s2));

  logic         mat_a [3];
  logic         pul_a [3];
  logic [31:0]  off_a [3];
  logic [31:0]  cnt_a [3];
  logic [D-1:0] sv_a  [3];

  assign mat_a[0] = m0;  assign mat_a[1] = m1;  assign mat_a[2] = m2;
  assign pul_a[0] = p0;  assign pul_a[1] = p1;  assign pul_a[2] = p2;
  assign off_a[0] = {16'd0, o0};  assign off_a[1] = {16'd0, o1};  assign off_a[2] = {28'd0, o2};
  assign cnt_a[0] = {24'd0, c0};  assign cnt_a[1] = {24'd0, c1};  assign cnt_a[2] = {24'd0, c2};
  assign sv_a[0]  = s0;  assign sv_a[1]  = s1;  assign sv_a[2]  = s2;

  typedef struct { int inst; int off; int cyc; } pulse_t;
  typedef struct { int inst; logic mt; int off; logic [D-1:0] sv; int cnt; } snap_t;

  pulse_t pq[$];
  snap_t  sq[$];
  int     n_vec = 0;
  int     n_err = 0;
  int     cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s u%0d: got 0x%0h expected 0x%0h (t=%0t)", name, inst, act, exp, $time);
    end
  endtask

  function automatic int find_pulse(input int inst);
    for (int k = 0; k < pq.size(); k++) if (pq[k].inst == inst) return k;
    return -1;
  endfunction

  // Monitor: consumes expected first-match pulses and status snapshots.
  always @(negedge clk) begin
    int    idx;
    snap_t s;
    for (int i = 0; i < 3; i++) begin
      if (pul_a[i] === 1'b1) begin
        idx = find_pulse(i);
        if (idx < 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_pulse u%0d: got 1 expected 0 (t=%0t)", i, $time);
        end else begin
          chk("pulse_offset", i, off_a[i], pq[idx].off);
          chk("pulse_cycle", i, cyc, pq[idx].cyc);
          pq.delete(idx);
        end
      end
    end
    while (sq.size() > 0) begin
      s = sq.pop_front();
      chk("match",        s.inst, {31'd0, mat_a[s.inst]}, {31'd0, s.mt});
      chk("match_offset", s.inst, off_a[s.inst], s.off);
      chk("state_vec",    s.inst, {21'd0, sv_a[s.inst]}, {21'd0, s.sv});
      chk("match_count",  s.inst, cnt_a[s.inst], s.cnt);
      chk("pulse_idle",   s.inst, {31'd0, pul_a[s.inst]}, 32'd0);
    end
  end

  function automatic logic [NC-1:0] cls_of(input byte b);
    logic [NC-1:0] v;
    v    = '0;
    v[0] = (b == "p");
    v[1] = (b == "l");
    v[2] = (b == "s");
    v[3] = (b == "e");
    v[4] = (b == "c");
    v[5] = (b == "_");
    v[6] = (b >= "0" && b <= "9") || (b >= "a" && b <= "z") || (b >= "A" && b <= "Z");
    v[7] = (b == ".");
    v[8] = (b == "x");
    return v;
  endfunction

  task automatic idle(input int n);
    en = 1'b0;
    sod = 1'b0;
    cls_in = '0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_sod();
    sod = 1'b1;
    en = 1'b0;
    @(posedge clk); #1;
    sod = 1'b0;
  endtask

  task automatic send(input byte b);
    en = 1'b1;
    cls_in = cls_of(b);
    @(posedge clk); #1;
    en = 1'b0;
    cls_in = '0;
  endtask

  // hN = string index of the byte completing the first match on uN (-1: none), oN = offset.
  task automatic play(input string s, input int h0, input int o0_e, input int h1, input int o1_e,
                      input int h2, input int o2_e, input bit gaps);
    int h[3];
    int o[3];
    h = '{h0, h1, h2};
    o = '{o0_e, o1_e, o2_e};
    for (int k = 0; k < s.len(); k++) begin
      send(s[k]);
      for (int i = 0; i < 3; i++) if (h[i] == k) pq.push_back('{i, o[i], cyc});
      if (gaps) idle($urandom_range(1, 5));
    end
  endtask

  task automatic expect_all(input logic [2:0] mt, input int f0, input int f1, input int f2,
                            input logic [D-1:0] v0, input logic [D-1:0] v1, input logic [D-1:0] v2,
                            input int n0, input int n1, input int n2);
    idle(2);
    n_vec++;
    if (pq.size() != 0) begin
      n_err++;
      $display("FAIL missed_pulse: got %0d pending expected 0 (t=%0t)", pq.size(), $time);
      pq.delete();
    end
    sq.push_back('{0, mt[0], f0, v0, n0 * CNT_ON});
    sq.push_back('{1, mt[1], f1, v1, n1 * CNT_ON});
    sq.push_back('{2, mt[2], f2, v2, n2 * CNT_ON});
    idle(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    string fill;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    expect_all(3'b000, 0, 0, 0, '0, '0, '0, 0, 0, 0);

    // Unanchored hit at byte 14, then a filler byte drains the vector.
    do_sod();
    play("xxplsec_ab1.exe", 14, 14, -1, 0, 14, 14, 1'b0);
    expect_all(3'b101, 14, 0, 14, 11'h400, '0, 11'h400, 1, 0, 1);
    send(" ");
    expect_all(3'b101, 14, 0, 14, '0, '0, '0, 1, 0, 1);

    // Anchoring: leading junk blocks u1 only.
    do_sod();
    play("xplsec_a.exe", 11, 11, -1, 0, 11, 11, 1'b0);
    expect_all(3'b101, 11, 0, 11, 11'h400, '0, 11'h400, 1, 0, 1);
    do_sod();
    play("plsec_a.exe", 10, 10, 10, 10, 10, 10, 1'b0);
    expect_all(3'b111, 10, 10, 10, 11'h400, 11'h400, 11'h400, 1, 1, 1);

    // sod splits a match; byte counter restarts.
    do_sod();
    play("plsec_ab", -1, 0, -1, 0, -1, 0, 1'b0);
    do_sod();
    play(".exe", -1, 0, -1, 0, -1, 0, 1'b0);
    expect_all(3'b000, 0, 0, 0, '0, '0, '0, 0, 0, 0);
    play("plsec_a.exe", 10, 14, -1, 0, 10, 14, 1'b0);
    expect_all(3'b101, 14, 0, 14, 11'h400, '0, 11'h400, 1, 0, 1);

    // en gaps: state holds, offset unchanged.
    do_sod();
    play("xxplsec_", -1, 0, -1, 0, -1, 0, 1'b1);
    expect_all(3'b000, 0, 0, 0, 11'h020, '0, 11'h020, 0, 0, 0);
    play("ab", -1, 0, -1, 0, -1, 0, 1'b1);
    expect_all(3'b000, 0, 0, 0, 11'h040, '0, 11'h040, 0, 0, 0);
    play("1.exe", 4, 14, -1, 0, 4, 14, 1'b1);
    expect_all(3'b101, 14, 0, 14, 11'h400, '0, 11'h400, 1, 0, 1);

    // sod with en on a 'p': the byte is discarded.
    do_sod();
    play("pl", -1, 0, -1, 0, -1, 0, 1'b0);
    sod = 1'b1;
    send("p");
    sod = 1'b0;
    play("lsec_a.exe", -1, 0, -1, 0, -1, 0, 1'b0);
    expect_all(3'b000, 0, 0, 0, '0, '0, '0, 0, 0, 0);

    // Offset saturation on the 4-bit instance.
    do_sod();
    fill = "";
    for (int k = 0; k < 20; k++) fill = {fill, " "};
    play({fill, "plsec_a.exe"}, 30, 30, -1, 0, 30, 15, 1'b0);
    expect_all(3'b101, 30, 0, 15, 11'h400, '0, 11'h400, 1, 0, 1);

    // Back-to-back completions: one pulse, first offset kept.
    do_sod();
    play("plsec_a.exeplsec_b.exe", 10, 10, 10, 10, 10, 10, 1'b0);
    expect_all(3'b111, 10, 10, 10, 11'h400, '0, 11'h400, 2, 1, 2);

    // rst dominates a concurrent byte.
    rst = 1'b1;
    en = 1'b1;
    cls_in = cls_of("p");
    @(posedge clk); #1;
    rst = 1'b0;
    expect_all(3'b000, 0, 0, 0, '0, '0, '0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
